// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, byte slot, and baud divider math.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    typedef enum logic {
        HI = 1'b0,
        LO = 1'b1
    } byte_idx_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int calc_cycles(input int clk_fre, input int baud_rate);
        return (clk_fre * 1_000_000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// One-byte UART frame serializer; back-to-back frames when start is held at the stop end.
// UART_WORD_TX_PARITY_EN adds an even parity bit (8E1), otherwise 8N1.
module uart_frame_ser
    import uart_pkg::*;
#(
    parameter int CYCLES = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       last
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;

    assign tick = (cnt == CNT_MAX);
    // Final clock of the stop bit: the parent may chain the next frame here.
    assign last = (state == STOP) && tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            if (state != IDLE)
                cnt <= tick ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state <= START;
                    shreg <= data;
                    tx    <= 1'b0;
                end
                START: if (tick) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shreg[0];
                end
                DATA: if (tick) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_WORD_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= ^shreg;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx      <= shreg[bit_idx + 3'd1];
                    end
                end
`ifdef UART_WORD_TX_PARITY_EN
                PARITY: if (tick) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: if (tick) begin
                    if (start) begin
                        state <= START;
                        shreg <= data;
                        tx    <= 1'b0;
                    end else begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// 16-bit word to two UART frames (high byte first) with valid/ready backpressure.
// Define UART_WORD_TX_PARITY_EN for 8E1 frames; default is 8N1.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tx_data,
    input  logic        tx_data_valid,
    output logic        tx_data_ready,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int CYCLES = calc_cycles(CLK_FRE, BAUD_RATE);

    logic [15:0] word_q;
    logic [15:0] word_src;
    byte_idx_t   byte_idx;
    logic        accept;
    logic        frame_start;
    logic        frame_last;
    logic [7:0]  frame_byte;

    assign accept   = tx_data_valid && tx_data_ready;
    assign tx_busy  = !tx_data_ready;
    // High byte launches straight from the input on acceptance; low byte from the capture.
    assign word_src    = accept ? tx_data : word_q;
    assign frame_byte  = accept ? word_src[15:8] : word_src[7:0];
    assign frame_start = accept || (frame_last && byte_idx == HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_ready <= 1'b1;
            word_q        <= '0;
            byte_idx      <= HI;
        end else if (accept) begin
            tx_data_ready <= 1'b0;
            word_q        <= tx_data;
            byte_idx      <= HI;
        end else if (frame_last) begin
            if (byte_idx == HI)
                byte_idx <= LO;
            else
                tx_data_ready <= 1'b1;
        end
    end

    uart_frame_ser #(.CYCLES(CYCLES)) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .start (frame_start),
        .data  (frame_byte),
        .tx    (uart_tx),
        .last  (frame_last)
    );

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: driver pushes expected bytes/start cycles, line monitor pops.
module tb_uart_word_tx;

    localparam int C = 25;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int FRAME = 11 * C;
`else
    localparam int FRAME = 10 * C;
`endif
    localparam int WORD = 2 * FRAME;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        uart_tx;
    logic        tx_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_rst  = 0;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;
    exp_t sb[$];

    uart_word_tx #(.CLK_FRE(50), .BAUD_RATE(2_000_000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) n_rst <= n_rst + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    endtask

    // Called at a negedge; returns at the negedge after acceptance with valid still high.
    task automatic send_word(input logic [15:0] w, output int acc);
        int n;
        exp_t e;
        n = 0;
        tx_data = w;
        tx_data_valid = 1'b1;
        while (!tx_data_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", tx_data_ready, 1'b1);
        acc = cyc;
        e.b = w[15:8]; e.t = acc + 1;         sb.push_back(e);
        e.b = w[7:0];  e.t = acc + 1 + FRAME; sb.push_back(e);
        @(negedge clk);
        chk("start_lat", uart_tx, 1'b0);
        chk("ready_low", tx_data_ready, 1'b0);
        chk("busy_high", tx_busy, 1'b1);
    endtask

    task automatic wait_ready(input int acc);
        int n;
        n = 0;
        while (!tx_data_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("word_len", cyc - acc - 1, WORD);
    endtask

    // Line monitor: mid-bit sampling, frames interrupted by reset are dropped.
    always begin : mon
        int t0, r0;
        logic [7:0] b;
        logic st, pbit, sbit;
        exp_t e;
        @(negedge clk);
        if (rst_n && uart_tx === 1'b0) begin
            t0 = cyc;
            r0 = n_rst;
            pbit = 1'b0;
            repeat (C / 2) @(negedge clk);
            st = uart_tx;
            for (int k = 0; k < 8; k++) begin
                repeat (C) @(negedge clk);
                b[k] = uart_tx;
            end
`ifdef UART_WORD_TX_PARITY_EN
            repeat (C) @(negedge clk);
            pbit = uart_tx;
`endif
            repeat (C) @(negedge clk);
            sbit = uart_tx;
            if (n_rst == r0 && rst_n) begin
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("byte", b, e.b);
                    chk("start_cyc", t0, e.t);
                end
                chk("start_bit", st, 1'b0);
                chk("stop_bit", sbit, 1'b1);
`ifdef UART_WORD_TX_PARITY_EN
                chk("parity", pbit, ^b);
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a1, a2;
        rst_n = 1'b0;
        tx_data = '0;
        tx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_ready", tx_data_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single word, latency and length
        send_word(16'hA55A, a1);
        tx_data_valid = 1'b0;
        wait_ready(a1);

        // valid held high across two words: accepted on first ready cycle
        repeat (5) @(negedge clk);
        send_word(16'h1234, a1);
        send_word(16'h5678, a2);
        tx_data_valid = 1'b0;
        chk("b2b_gap", a2 - a1, WORD + 1);
        wait_ready(a2);

        // input changes after acceptance are ignored
        send_word(16'h00FF, a1);
        tx_data = 16'hFFFF;
        tx_data_valid = 1'b0;
        wait_ready(a1);

        // valid toggling while busy is not accepted
        send_word(16'hC3A5, a1);
        for (int i = 0; i < 20; i++) begin
            chk("busy_hold", tx_data_ready, 1'b0);
            tx_data = 16'hDEAD;
            tx_data_valid = i[0];
            repeat (10) @(negedge clk);
        end
        tx_data_valid = 1'b0;
        wait_ready(a1);

        // parity pattern (both parity bits 1 in the 8E1 build)
        send_word(16'h0107, a1);
        tx_data_valid = 1'b0;
        wait_ready(a1);

        // asynchronous reset mid-frame while the line is low
        send_word(16'h00EF, a1);
        tx_data_valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_line", uart_tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", uart_tx, 1'b1);
        chk("mid_rst_ready", tx_data_ready, 1'b1);
        chk("mid_rst_busy", tx_busy, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * C) @(negedge clk);

        send_word(16'h5AA5, a1);
        tx_data_valid = 1'b0;
        wait_ready(a1);

        repeat (2 * C) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Transmit-side bridge that takes 16-bit words from the host-facing datapath and sends each as two back-to-back UART 8N1 frames on one serial pin, high byte first. It is the PC-link counterpart to the word receiver, which reassembles two bytes (high then low) into a 16-bit word. It has its own baud-rate divider. It applies real valid/ready backpressure, so upstream never overruns a frame in flight.

Parameters:
CLK_FRE, 50, system clock frequency in MHz
BAUD_RATE, 2_000_000, serial bit rate in bit/s; CYCLES = CLK_FRE*1_000_000/BAUD_RATE (truncating), must be >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  16  word to send; [15:8] goes first
tx_data_valid  in  1  upstream word valid
tx_data_ready  out  1  block can accept a word this cycle
uart_tx  out  1  serial line, idle high
tx_busy  out  1  word transfer in progress

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: uart_tx=1, tx_data_ready=1, tx_busy=0. State is IDLE, byte index is HI, and all counters are 0.
- Handshake:
  - A word is accepted on the clock edge where tx_data_valid && tx_data_ready.
  - tx_data is captured into an internal 16-bit register at acceptance only; later changes to tx_data are ignored.
  - tx_data_ready deasserts the cycle after acceptance and stays low until the word completes. tx_busy mirrors !tx_data_ready.
- FSM states:
  - IDLE: uart_tx=1. On acceptance go to START with byte index HI.
  - START: uart_tx=0 for CYCLES clocks, then go to DATA.
  - DATA: 8 bits, LSB first, each held CYCLES clocks. After bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY: optional; see Optional Feature.
  - STOP: uart_tx=1 for CYCLES clocks. At the end: if byte index is HI, set it to LO and go to START with no gap; if LO, go to IDLE.
- Latency: the start bit appears on uart_tx in the cycle after acceptance. A word occupies 20*CYCLES clocks, or 22*CYCLES with parity.
- tx_data_ready reasserts in the first IDLE cycle. A word accepted in that cycle starts its start bit the next cycle, so the inter-word gap is stop bit plus 1 clock.
- The bit counter counts 0..CYCLES-1 and wraps. Data bit index is 0..7.
- Reset mid-frame: uart_tx goes to 1 immediately (asynchronous) and the frame is abandoned. No partial resume.
- uart_tx is driven from a flop, so the line never glitches.

Optional Feature:
Macro UART_WORD_TX_PARITY_EN.
- Defined: after each byte's bit 7, one even-parity bit (XOR of the 8 data bits) is sent for CYCLES clocks before the stop bit. Frame becomes 8E1.
- Undefined: the PARITY state and its logic are not compiled. Frame is 8N1.
- The receive side must be built with the same setting.

Decomposition:
- Shared package uart_pkg holds:
  - the state typedef (IDLE, START, DATA, PARITY, STOP);
  - the byte-index constants HI/LO;
  - the CYCLES computation as a constant function of CLK_FRE and BAUD_RATE;
  - constants for data bits (8) and stop bits (1).
- One natural sub-module, uart_frame_ser: serializes one byte frame with a start/done handshake. uart_word_tx sequences two frames and owns the word handshake.

Test Plan:
1. Reset with CLK_FRE=50, BAUD_RATE=2_000_000 -> uart_tx=1, tx_data_ready=1, tx_busy=0. Assert rst_n low mid-frame -> uart_tx=1 within the same cycle.
2. Single word 16'hA55A -> start bit 1 cycle after acceptance. Line shows 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1, each bit 25 cycles. Total 500 cycles; tx_data_ready high again at cycle 501.
3. Hold tx_data_valid high with 16'h1234, then 16'h5678 -> the second word is accepted on the first ready cycle. Bytes 0x12,0x34,0x56,0x78 appear in order with exactly 1 extra idle clock between words.
4. Change tx_data to 16'hFFFF one cycle after accepting 16'h00FF -> bytes 0x00 then 0xFF are sent unchanged.
5. Toggle tx_data_valid while tx_data_ready=0 -> no acceptance, and the line waveform is unchanged.
6. Parity build with 16'h0107 -> parity bit 1 after 0x01 and 1 after 0x07. Word lasts 550 cycles.
